vec_alu_issue_buffer: RTL and testbench

- 2-entry skid/issue buffer placed directly upstream of the vectorial ALU.
- Captures decoded operand vectors A and B, the 3-bit ALU select, and the destination register tag from the decode/operand-read stage.
- Presents them to the ALU from registered outputs under a valid/ready handshake.
- Isolates ALU-side back-pressure (writeback stall) from decode without a combinational ready path.

---
 rtl/vec_alu_issue_buffer.sv | 132 +++++++++++++
 tb/tb_vec_alu_issue_buffer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_issue_buffer.sv
// Two-entry skid/issue buffer feeding the vector ALU; all handshake outputs are registered.
// Optional stall counter output enabled by defining VEC_ISSUE_STALL_CNT_EN.
module vec_alu_issue_buffer #(
    parameter int N  = 128,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic [2:0]    in_sel,
    input  logic [RW-1:0] in_rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_a,
    output logic [N-1:0]  out_b,
    output logic [2:0]    out_sel,
    output logic [RW-1:0] out_rd,
`ifdef VEC_ISSUE_STALL_CNT_EN
    output logic [31:0]   stall_cycles,
`endif
    output logic [1:0]    count
);

    localparam int PW = 2 * N + 3 + RW;

    logic [1:0]    count_q, count_d;
    logic          valid_q, valid_d;
    logic          ready_q, ready_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] in_pl_s;
    logic          push_s;
    logic          pop_s;

    assign in_pl_s = {in_a, in_b, in_sel, in_rd};
    assign push_s  = in_valid && ready_q;
    assign pop_s   = valid_q && out_ready;

    // Next-state: occupancy and entry movement; flush overrides push/pop.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_s) begin
                        head_d  = in_pl_s;
                        count_d = 2'd1;
                    end else begin
                        count_d = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_d  = in_pl_s;
                        count_d = 2'd1;
                    end else if (push_s) begin
                        tail_d  = in_pl_s;
                        count_d = 2'd2;
                    end else if (pop_s) begin
                        count_d = 2'd0;
                    end else begin
                        count_d = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_d  = tail_q;
                        count_d = 2'd1;
                    end else begin
                        count_d = 2'd2;
                    end
                end
                default: begin
                    count_d = 2'd0;
                end
            endcase
        end
        valid_d = (count_d != 2'd0);
        ready_d = (count_d != 2'd2);
    end

    // Control and head registers; the head is reset so outputs read zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            head_q  <= {PW{1'b0}};
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            head_q  <= head_d;
        end
    end

    // Second entry is only observable through the head, so it carries no reset.
    always_ff @(posedge clk) begin
        tail_q <= tail_d;
    end

`ifdef VEC_ISSUE_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of cycles the ALU holds off a valid head; flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if (valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_cycles = stall_q;
`endif

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign count     = count_q;
    assign {out_a, out_b, out_sel, out_rd} = head_q;

endmodule

// File: tb/tb_vec_alu_issue_buffer.sv
// Self-checking bench for vec_alu_issue_buffer: directed tables, hand sequences and a
// queue-based reference model driven with random traffic.
module tb_vec_alu_issue_buffer;

    localparam int N  = 128;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_a, in_b;
    logic [2:0]    in_sel;
    logic [RW-1:0] in_rd;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_a, out_b;
    logic [2:0]    out_sel;
    logic [RW-1:0] out_rd;
    logic [1:0]    count;
`ifdef VEC_ISSUE_STALL_CNT_EN
    logic [31:0]   stall_cycles;
`endif

    vec_alu_issue_buffer #(.N(N), .RW(RW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_sel(out_sel), .out_rd(out_rd),
`ifdef VEC_ISSUE_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [2:0]    sel;
        logic [RW-1:0] rd;
    } pl_t;

    typedef struct {
        logic          iv;
        logic          ordy;
        logic [RW-1:0] rd;
        logic [1:0]    ecnt;
        logic          evld;
        logic          erdy;
        logic [RW-1:0] erd;
    } vec_t;

    pl_t  mq[$];
    pl_t  last_head;
    int   stall_m;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [N-1:0] mk_a(input logic [RW-1:0] rd);
        return {16{3'b101, rd}};
    endfunction

    function automatic logic [N-1:0] mk_b(input logic [RW-1:0] rd);
        return {16{rd, 3'b010}};
    endfunction

    function automatic logic [N-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        mq.delete();
        last_head = '0;
        stall_m   = 0;
    endtask

    // One clock: drive inputs, advance model, then compare everything against the model.
    task automatic cyc(input logic iv, input logic ordy, input logic fl,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] sel, input logic [RW-1:0] rd);
        pl_t p;
        bit  can_push, do_push, do_pop;
        pl_t exp_head;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_a = a; in_b = b; in_sel = sel; in_rd = rd;
        p = '{a: a, b: b, sel: sel, rd: rd};
        can_push = (mq.size() < 2);
        do_push  = iv && can_push;
        do_pop   = (mq.size() > 0) && ordy;
        if (mq.size() > 0 && !ordy && stall_m != 32'hFFFF_FFFF) stall_m++;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(p);
        end
        if (mq.size() > 0) last_head = mq[0];
        exp_head = last_head;
        @(posedge clk);
        #1;
        chk("count", 264'(count), 264'(mq.size()));
        chk("out_valid", 264'(out_valid), 264'(mq.size() > 0));
        chk("in_ready", 264'(in_ready), 264'(mq.size() < 2));
        chk("head", 264'({out_a, out_b, out_sel, out_rd}), 264'(exp_head));
`ifdef VEC_ISSUE_STALL_CNT_EN
        chk("stall_cycles", 264'(stall_cycles), 264'(stall_m));
`endif
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, ordy, 1'b0, '0, '0, 3'd0, '0);
    endtask

    task automatic push_rd(input logic ordy, input logic [RW-1:0] rd);
        cyc(1'b1, ordy, 1'b0, mk_a(rd), mk_b(rd), rd[2:0], rd);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sel = '0; in_rd = '0;
        model_reset();

        tbl[0] = '{iv: 1'b1, ordy: 1'b0, rd: 5'd1, ecnt: 2'd1, evld: 1'b1, erdy: 1'b1, erd: 5'd1};
        tbl[1] = '{iv: 1'b1, ordy: 1'b0, rd: 5'd2, ecnt: 2'd2, evld: 1'b1, erdy: 1'b0, erd: 5'd1};
        tbl[2] = '{iv: 1'b1, ordy: 1'b0, rd: 5'd3, ecnt: 2'd2, evld: 1'b1, erdy: 1'b0, erd: 5'd1};
        tbl[3] = '{iv: 1'b0, ordy: 1'b1, rd: 5'd0, ecnt: 2'd1, evld: 1'b1, erdy: 1'b1, erd: 5'd2};
        tbl[4] = '{iv: 1'b0, ordy: 1'b1, rd: 5'd0, ecnt: 2'd0, evld: 1'b0, erdy: 1'b1, erd: 5'd2};
        tbl[5] = '{iv: 1'b0, ordy: 1'b1, rd: 5'd0, ecnt: 2'd0, evld: 1'b0, erdy: 1'b1, erd: 5'd2};

        #6;
        chk("rst_count", 264'(count), 264'(2'd0));
        chk("rst_valid", 264'(out_valid), 264'(1'b0));
        chk("rst_head", 264'({out_a, out_b, out_sel, out_rd}), 264'(0));
        #6 rst = 1'b0;
        #1;
        chk("rst_in_ready", 264'(in_ready), 264'(1'b1));

        // Single entry through an empty buffer
        cyc(1'b1, 1'b1, 1'b0, 128'h0101, 128'h0202, 3'b010, 5'd3);
        chk("single_valid", 264'(out_valid), 264'(1'b1));
        chk("single_a", 264'(out_a), 264'(128'h0101));
        chk("single_b", 264'(out_b), 264'(128'h0202));
        chk("single_sel", 264'(out_sel), 264'(3'b010));
        chk("single_rd", 264'(out_rd), 264'(5'd3));
        chk("single_cnt", 264'(count), 264'(2'd1));
        idle(1'b1);
        chk("single_drain_valid", 264'(out_valid), 264'(1'b0));
        chk("single_drain_cnt", 264'(count), 264'(2'd0));

        // Back-pressure table: fill, reject third, drain in order, empty pop ignored
        for (int i = 0; i < 6; i++) begin
            cyc(tbl[i].iv, tbl[i].ordy, 1'b0, mk_a(tbl[i].rd), mk_b(tbl[i].rd),
                tbl[i].rd[2:0], tbl[i].rd);
            chk($sformatf("bp%0d_cnt", i), 264'(count), 264'(tbl[i].ecnt));
            chk($sformatf("bp%0d_vld", i), 264'(out_valid), 264'(tbl[i].evld));
            chk($sformatf("bp%0d_rdy", i), 264'(in_ready), 264'(tbl[i].erdy));
            chk($sformatf("bp%0d_rd", i), 264'(out_rd), 264'(tbl[i].erd));
        end

        // Streaming: every selector code, no bubbles
        for (int i = 0; i < 8; i++) begin
            push_rd(1'b1, 5'(i));
            chk($sformatf("stream%0d_cnt", i), 264'(count), 264'(2'd1));
            chk($sformatf("stream%0d_rdy", i), 264'(in_ready), 264'(1'b1));
            chk($sformatf("stream%0d_rd", i), 264'(out_rd), 264'(i));
            chk($sformatf("stream%0d_sel", i), 264'(out_sel), 264'(i));
        end
        idle(1'b1);

        // Flush with concurrent push and pop while full
        push_rd(1'b0, 5'd4);
        push_rd(1'b0, 5'd5);
        cyc(1'b1, 1'b1, 1'b1, mk_a(5'd9), mk_b(5'd9), 3'd1, 5'd9);
        chk("flush_cnt", 264'(count), 264'(2'd0));
        chk("flush_vld", 264'(out_valid), 264'(1'b0));
        chk("flush_rdy", 264'(in_ready), 264'(1'b1));
        idle(1'b1);
        chk("flush_no_ghost", 264'(out_valid), 264'(1'b0));

        // Asynchronous reset between edges while full
        push_rd(1'b0, 5'd6);
        push_rd(1'b0, 5'd7);
        in_valid = 1'b0; out_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_vld", 264'(out_valid), 264'(1'b0));
        chk("arst_cnt", 264'(count), 264'(2'd0));
        chk("arst_a", 264'(out_a), 264'(0));
        chk("arst_sel", 264'(out_sel), 264'(3'd0));
        model_reset();
        #2 rst = 1'b0;
        idle(1'b0);

        // Stall window: five held cycles, then consume; flush afterwards
        push_rd(1'b0, 5'd10);
        for (int i = 0; i < 5; i++) idle(1'b0);
        idle(1'b1);
`ifdef VEC_ISSUE_STALL_CNT_EN
        chk("stall_five", 264'(stall_cycles), 264'(32'd5));
`endif
        cyc(1'b0, 1'b0, 1'b1, '0, '0, 3'd0, '0);
`ifdef VEC_ISSUE_STALL_CNT_EN
        chk("stall_after_flush", 264'(stall_cycles), 264'(32'd5));
`endif

        // Random traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 15) == 0), rnd128(), rnd128(),
                3'($urandom), 5'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
